// File: rtl/debug_dump_engine.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : debug_dump_engine
// Description : Serial readout sequencer for the MIPS debug path. On i_start
//               it streams PC, an optional range of register-bank words and
//               an optional range of data-memory words (little-endian, one
//               UART byte at a time), then a trailing XOR checksum byte.
//               It drives the register-bank and data-memory debug read ports
//               directly (1-cycle read latency).
// Ports       : i_clock/i_reset (async active-low), i_start, i_abort, i_mode
//               (00 all, 01 PC, 10 PC+regs, 11 PC+mem), i_pc_value,
//               i_rb_data/o_rb_addr/o_rb_read_enable, i_mem_data/o_mem_addr/
//               o_mem_read_enable, o_tx_data/o_tx_start/i_tx_done (UART),
//               o_busy, o_done, o_byte_count.
// Revision    : 1.0 - initial release
//============================================================================
module debug_dump_engine #(
    parameter int NB_BYTE     = 8,
    parameter int NB_DATA     = 32,
    parameter int N_REGS      = 32,
    parameter int NB_RB_ADDR  = 5,
    parameter int N_MEM_WORDS = 32,
    parameter int NB_MEM_ADDR = 5,
    parameter int NB_COUNT    = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [1:0]             i_mode,
    input  logic [NB_DATA-1:0]     i_pc_value,
    input  logic [NB_DATA-1:0]     i_rb_data,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic                   i_tx_done,
    output logic [NB_RB_ADDR-1:0]  o_rb_addr,
    output logic                   o_rb_read_enable,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    output logic                   o_mem_read_enable,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [NB_COUNT-1:0]    o_byte_count
);

    localparam int c_BYTES   = NB_DATA / NB_BYTE;
    localparam int c_NB_BIDX = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_NB_BIDX-1:0]   c_LAST_BYTE = c_NB_BIDX'(c_BYTES - 1);
    localparam logic [NB_RB_ADDR-1:0]  c_LAST_RB   = NB_RB_ADDR'(N_REGS - 1);
    localparam logic [NB_MEM_ADDR-1:0] c_LAST_MEM  = NB_MEM_ADDR'(N_MEM_WORDS - 1);

    // Which part of the frame the word in r_shift belongs to
    localparam logic [1:0] c_SEC_PC  = 2'd0;
    localparam logic [1:0] c_SEC_RB  = 2'd1;
    localparam logic [1:0] c_SEC_MEM = 2'd2;
    localparam logic [1:0] c_SEC_CHK = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD_PC = 4'd1,
        S_RB_REQ  = 4'd2,
        S_RB_CAP  = 4'd3,
        S_MEM_REQ = 4'd4,
        S_MEM_CAP = 4'd5,
        S_SEND    = 4'd6,
        S_WAIT_TX = 4'd7,
        S_CHK     = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    state_t                   w_after_word;
    logic [1:0]               r_mode;
    logic [1:0]               r_section;
    logic [NB_DATA-1:0]       r_shift;
    logic [c_NB_BIDX-1:0]     r_byte_idx;
    logic [NB_RB_ADDR-1:0]    r_rb_idx;
    logic [NB_MEM_ADDR-1:0]   r_mem_idx;
    logic [NB_BYTE-1:0]       r_chk;
    logic [NB_COUNT-1:0]      r_byte_count;
    logic                     w_regs_en;
    logic                     w_mem_en;
    logic                     w_last_byte;

    assign w_regs_en   = (r_mode == 2'b00) || (r_mode == 2'b10);
    assign w_mem_en    = (r_mode == 2'b00) || (r_mode == 2'b11);
    // The checksum is a single byte; every other section sends a full word
    assign w_last_byte = (r_section == c_SEC_CHK) || (r_byte_idx == c_LAST_BYTE);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_after_word = S_CHK;
        // Successor once the last byte of the current word is acknowledged
        case (r_section)
            c_SEC_PC: begin
                if (w_regs_en)     w_after_word = S_RB_REQ;
                else if (w_mem_en) w_after_word = S_MEM_REQ;
                else               w_after_word = S_CHK;
            end
            c_SEC_RB: begin
                if (r_rb_idx != c_LAST_RB) w_after_word = S_RB_REQ;
                else if (w_mem_en)         w_after_word = S_MEM_REQ;
                else                       w_after_word = S_CHK;
            end
            c_SEC_MEM: begin
                if (r_mem_idx != c_LAST_MEM) w_after_word = S_MEM_REQ;
                else                         w_after_word = S_CHK;
            end
            default: w_after_word = S_DONE;
        endcase

        case (r_state)
            S_IDLE:    if (i_start) w_next = S_LOAD_PC;
            S_LOAD_PC: w_next = S_SEND;
            S_RB_REQ:  w_next = S_RB_CAP;
            S_RB_CAP:  w_next = S_SEND;
            S_MEM_REQ: w_next = S_MEM_CAP;
            S_MEM_CAP: w_next = S_SEND;
            S_CHK:     w_next = S_SEND;
            S_SEND:    w_next = S_WAIT_TX;
            S_WAIT_TX: if (i_tx_done) w_next = w_last_byte ? w_after_word : S_SEND;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase

        if (i_abort) w_next = S_IDLE;
    end

    // Datapath; an abort freezes everything (including the byte count)
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_mode       <= 2'b00;
            r_section    <= c_SEC_PC;
            r_shift      <= '0;
            r_byte_idx   <= '0;
            r_rb_idx     <= '0;
            r_mem_idx    <= '0;
            r_chk        <= '0;
            r_byte_count <= '0;
        end else if (!i_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode       <= i_mode;
                        r_chk        <= '0;
                        r_byte_count <= '0;
                        r_rb_idx     <= '0;
                        r_mem_idx    <= '0;
                    end
                end
                S_LOAD_PC: begin
                    r_shift    <= i_pc_value;
                    r_byte_idx <= '0;
                    r_section  <= c_SEC_PC;
                end
                S_RB_CAP: begin
                    r_shift    <= i_rb_data;
                    r_byte_idx <= '0;
                    r_section  <= c_SEC_RB;
                end
                S_MEM_CAP: begin
                    r_shift    <= i_mem_data;
                    r_byte_idx <= '0;
                    r_section  <= c_SEC_MEM;
                end
                S_CHK: begin
                    r_shift    <= NB_DATA'(r_chk);
                    r_byte_idx <= '0;
                    r_section  <= c_SEC_CHK;
                end
                S_WAIT_TX: begin
                    if (i_tx_done) begin
                        r_chk <= r_chk ^ r_shift[NB_BYTE-1:0];
                        if (r_byte_count != '1)
                            r_byte_count <= r_byte_count + NB_COUNT'(1);
                        if (!w_last_byte) begin
                            r_shift    <= r_shift >> NB_BYTE;
                            r_byte_idx <= r_byte_idx + c_NB_BIDX'(1);
                        end else if ((r_section == c_SEC_RB) && (r_rb_idx != c_LAST_RB)) begin
                            r_rb_idx <= r_rb_idx + NB_RB_ADDR'(1);
                        end else if ((r_section == c_SEC_MEM) && (r_mem_idx != c_LAST_MEM)) begin
                            r_mem_idx <= r_mem_idx + NB_MEM_ADDR'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rb_addr         = r_rb_idx;
    assign o_mem_addr        = r_mem_idx;
    assign o_rb_read_enable  = (r_state == S_RB_REQ);
    assign o_mem_read_enable = (r_state == S_MEM_REQ);
    assign o_tx_data         = r_shift[NB_BYTE-1:0];
    assign o_tx_start        = (r_state == S_SEND);
    assign o_busy            = (r_state != S_IDLE);
    assign o_done            = (r_state == S_DONE);
    assign o_byte_count      = r_byte_count;

endmodule
`default_nettype wire
